// File: rtl/regwr_arbiter_pkg.sv
// Shared widths, default burst length and types for the register-file write
// arbiter. Imported by rr_arb2 and regwr_arbiter.
package regwr_arbiter_pkg;

    localparam int WORD_W        = 16;
    localparam int REG_IDX_W     = 3;
    localparam int BURST_MAX_DEF = 4;

    // Burst ownership; doubles as the arbiter FSM state.
    typedef enum logic [1:0] {
        BST_IDLE = 2'd0,
        BST_A    = 2'd1,
        BST_B    = 2'd2
    } burst_state_e;

    // One write to the register file.
    typedef struct packed {
        logic [REG_IDX_W-1:0] dr;
        logic [WORD_W-1:0]    data;
    } wr_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a locked-burst override.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   BST_IDLE | no burst; ties go to the requester not granted last
//   BST_A    | A owns a locked burst; A wins ties while r_cnt < BURST_MAX
//   BST_B    | B owns a locked burst; B wins ties while r_cnt < BURST_MAX
//
// r_cnt counts consecutive locked grants to the owner and saturates at
// BURST_MAX. Once saturated, a waiting peer wins the next tie through the
// round-robin pointer, because the owner was the last one granted.
module rr_arb2
    import regwr_arbiter_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_a_valid,
    input  logic i_a_lock,
    input  logic i_b_valid,
    input  logic i_b_lock,
    output logic o_a_grant,
    output logic o_b_grant
);

    localparam int               CNT_W   = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    burst_state_e     r_state;
    burst_state_e     w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_last_b;
    logic             w_last_b_nxt;
    logic             w_hold_a;
    logic             w_hold_b;

    // State register: burst owner, burst length and round-robin pointer.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state  <= BST_IDLE;
            r_cnt    <= '0;
            r_last_b <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_last_b <= w_last_b_nxt;
        end
    end

    // Grant decode; no grant is issued while reset is asserted.
    always_comb begin
        w_hold_a  = (r_state == BST_A) && (r_cnt < CNT_MAX);
        w_hold_b  = (r_state == BST_B) && (r_cnt < CNT_MAX);
        o_a_grant = 1'b0;
        o_b_grant = 1'b0;
        if (i_reset) begin
            if (i_a_valid && !i_b_valid) begin
                o_a_grant = 1'b1;
            end else if (!i_a_valid && i_b_valid) begin
                o_b_grant = 1'b1;
            end else if (i_a_valid && i_b_valid) begin
                if (w_hold_a) begin
                    o_a_grant = 1'b1;
                end else if (w_hold_b) begin
                    o_b_grant = 1'b1;
                end else if (r_last_b) begin
                    o_a_grant = 1'b1;
                end else begin
                    o_b_grant = 1'b1;
                end
            end
        end
    end

    // Next state: a locked grant starts or extends a burst; anything else ends it.
    always_comb begin
        w_cnt_inc    = (r_cnt == CNT_MAX) ? CNT_MAX : (r_cnt + CNT_ONE);
        w_state_nxt  = BST_IDLE;
        w_cnt_nxt    = '0;
        w_last_b_nxt = r_last_b;
        if (o_a_grant) begin
            w_last_b_nxt = 1'b0;
            if (i_a_lock) begin
                w_state_nxt = BST_A;
                w_cnt_nxt   = (r_state == BST_A) ? w_cnt_inc : CNT_ONE;
            end
        end else if (o_b_grant) begin
            w_last_b_nxt = 1'b1;
            if (i_b_lock) begin
                w_state_nxt = BST_B;
                w_cnt_nxt   = (r_state == BST_B) ? w_cnt_inc : CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/regwr_arbiter.sv
// Register-file write-port arbiter between the ALU writeback (A) and the
// memory load path (B). The winning request is staged for one cycle and then
// driven onto regWE/DR/Buss.
// Optional build macro REGWR_FWD_EN: bypass the staged write onto the read
// ports when its destination matches sr1/sr2.
module regwr_arbiter
    import regwr_arbiter_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_a_valid,
    input  logic                 i_a_lock,
    input  logic [REG_IDX_W-1:0] i_a_dr,
    input  logic [WORD_W-1:0]    i_a_data,
    output logic                 o_a_ready,
    input  logic                 i_b_valid,
    input  logic                 i_b_lock,
    input  logic [REG_IDX_W-1:0] i_b_dr,
    input  logic [WORD_W-1:0]    i_b_data,
    output logic                 o_b_ready,
    output logic                 o_regWE,
    output logic [REG_IDX_W-1:0] o_DR,
    output logic [WORD_W-1:0]    o_Buss,
    input  logic [REG_IDX_W-1:0] i_sr1,
    input  logic [REG_IDX_W-1:0] i_sr2,
    input  logic [WORD_W-1:0]    i_ra_in,
    input  logic [WORD_W-1:0]    i_rb_in,
    output logic [WORD_W-1:0]    o_ra_out,
    output logic [WORD_W-1:0]    o_rb_out
);

    logic    w_a_grant;
    logic    w_b_grant;
    logic    w_a_xfer;
    logic    w_b_xfer;
    wr_req_t w_req;
    wr_req_t r_stage;
    logic    r_we;

    rr_arb2 #(
        .BURST_MAX (BURST_MAX)
    ) u_rr_arb2 (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_a_valid (i_a_valid),
        .i_a_lock  (i_a_lock),
        .i_b_valid (i_b_valid),
        .i_b_lock  (i_b_lock),
        .o_a_grant (w_a_grant),
        .o_b_grant (w_b_grant)
    );

    assign o_a_ready = w_a_grant;
    assign o_b_ready = w_b_grant;

    // Select the request that transfers this cycle.
    always_comb begin
        w_a_xfer = i_a_valid & w_a_grant;
        w_b_xfer = i_b_valid & w_b_grant;
        if (w_a_xfer) begin
            w_req = '{dr: i_a_dr, data: i_a_data};
        end else begin
            w_req = '{dr: i_b_dr, data: i_b_data};
        end
    end

    // Stage the accepted write for the next cycle; DR/Buss hold when idle.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_we    <= 1'b0;
            r_stage <= '0;
        end else begin
            r_we <= w_a_xfer | w_b_xfer;
            if (w_a_xfer | w_b_xfer) begin
                r_stage <= w_req;
            end
        end
    end

    // A staged write is killed in the same cycle reset arrives, so it never
    // reaches the register file.
    assign o_regWE = r_we & i_reset;
    assign o_DR    = r_stage.dr;
    assign o_Buss  = r_stage.data;

`ifdef REGWR_FWD_EN
    // Bypass the write in flight onto the read ports on an address match.
    always_comb begin
        o_ra_out = (o_regWE && (o_DR == i_sr1)) ? o_Buss : i_ra_in;
        o_rb_out = (o_regWE && (o_DR == i_sr2)) ? o_Buss : i_rb_in;
    end
`else
    logic w_unused_sr;
    assign w_unused_sr = ^{i_sr1, i_sr2};

    // Read data passes straight through.
    always_comb begin
        o_ra_out = i_ra_in;
        o_rb_out = i_rb_in;
    end
`endif

endmodule

// File: tb/tb_regwr_arbiter.sv
// Testbench for regwr_arbiter: directed scenarios followed by random traffic,
// checked by a reference model feeding a scoreboard queue.
module tb_regwr_arbiter;
    import regwr_arbiter_pkg::*;

    localparam int BMAX = BURST_MAX_DEF;
`ifdef REGWR_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, a_lock, b_valid, b_lock;
    logic [2:0]  a_dr, b_dr, sr1, sr2, dr_o;
    logic [15:0] a_data, b_data, ra_in, rb_in, ra_out, rb_out, buss;
    logic        a_ready, b_ready, regwe;

    always #5 clk = ~clk;

    regwr_arbiter #(.BURST_MAX(BMAX)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_a_valid(a_valid), .i_a_lock(a_lock), .i_a_dr(a_dr), .i_a_data(a_data), .o_a_ready(a_ready),
        .i_b_valid(b_valid), .i_b_lock(b_lock), .i_b_dr(b_dr), .i_b_data(b_data), .o_b_ready(b_ready),
        .o_regWE(regwe), .o_DR(dr_o), .o_Buss(buss),
        .i_sr1(sr1), .i_sr2(sr2), .i_ra_in(ra_in), .i_rb_in(rb_in),
        .o_ra_out(ra_out), .o_rb_out(rb_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit        we;
        bit [2:0]  dr;
        bit [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    bit   mon_en = 1'b0;

    // Reference model state: burst owner (0 none, 1 A, 2 B), locked grants in
    // the current burst, last requester granted, and next-cycle write port.
    int        m_owner  = 0;
    int        m_cnt    = 0;
    int        m_last   = 2;
    bit        cur_we   = 1'b0;
    bit [2:0]  cur_dr   = 3'd0;
    bit [15:0] cur_data = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: decide the grant from the arbitration rules, check readies and
    // read-port data, then queue the write port values for the next cycle.
    always @(negedge clk) begin : model
        int        g;
        bit        lk;
        logic [15:0] e_ra, e_rb;
        g = 0;
        if (rst_n) begin
            if (a_valid && !b_valid)      g = 1;
            else if (b_valid && !a_valid) g = 2;
            else if (a_valid && b_valid) begin
                if (m_owner != 0 && m_cnt < BMAX) g = m_owner;
                else                              g = (m_last == 1) ? 2 : 1;
            end
        end
        e_ra = (FWD && cur_we && rst_n && cur_dr == sr1) ? cur_data : ra_in;
        e_rb = (FWD && cur_we && rst_n && cur_dr == sr2) ? cur_data : rb_in;
        chk("a_ready", a_ready, (g == 1));
        chk("b_ready", b_ready, (g == 2));
        chk("ra_out", ra_out, e_ra);
        chk("rb_out", rb_out, e_rb);
        if (!rst_n) begin
            m_owner = 0; m_cnt = 0; m_last = 2;
            cur_we = 1'b0; cur_dr = 3'd0; cur_data = 16'd0;
        end else if (g == 0) begin
            m_owner = 0; m_cnt = 0;
            cur_we = 1'b0;
        end else begin
            lk = (g == 1) ? a_lock : b_lock;
            if (lk) begin
                m_cnt   = (m_owner == g) ? ((m_cnt < BMAX) ? m_cnt + 1 : BMAX) : 1;
                m_owner = g;
            end else begin
                m_owner = 0; m_cnt = 0;
            end
            m_last   = g;
            cur_we   = 1'b1;
            cur_dr   = (g == 1) ? a_dr : b_dr;
            cur_data = (g == 1) ? a_data : b_data;
        end
        exp_q.push_back('{we: cur_we, dr: cur_dr, data: cur_data});
        mon_en = 1'b1;
    end

    // Monitor: each cycle, compare the write port with the queued expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (!rst_n) begin
                        chk("regWE_in_reset", regwe, 1'b0);
                    end else begin
                        chk("regWE", regwe, e.we);
                        chk("DR", dr_o, e.dr);
                        chk("Buss", buss, e.data);
                    end
                end
            end
        end
    end

    // One cycle: apply inputs after the edge, return just after the falling edge.
    task automatic cyc(input bit rn, input bit av, input bit al, input bit [2:0] adr, input bit [15:0] ad,
                       input bit bv, input bit bl, input bit [2:0] bdr, input bit [15:0] bd);
        @(posedge clk);
        #1;
        rst_n = rn;
        a_valid = av; a_lock = al; a_dr = adr; a_data = ad;
        b_valid = bv; b_lock = bl; b_dr = bdr; b_data = bd;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : stim
        int ai;
        rst_n = 1'b0;
        a_valid = 0; a_lock = 0; a_dr = 0; a_data = 0;
        b_valid = 0; b_lock = 0; b_dr = 0; b_data = 0;
        sr1 = 0; sr2 = 0; ra_in = 16'h5A5A; rb_in = 16'hA5A5;

        // Requests during reset are refused.
        cyc(0, 1, 1, 3'd4, 16'h4444, 1, 0, 3'd5, 16'h5555);
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_b_ready", b_ready, 1'b0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk("post_rst_regWE", regwe, 1'b0);
        chk("post_rst_DR", dr_o, 3'd0);
        chk("post_rst_Buss", buss, 16'h0000);

        // First tie goes to A, then B; writes in grant order.
        cyc(1, 1, 0, 3'd1, 16'h1111, 1, 0, 3'd2, 16'h2222);
        chk("tie_a_first", a_ready, 1'b1);
        chk("tie_b_wait", b_ready, 1'b0);
        cyc(1, 0, 0, 3'd1, 16'h1111, 1, 0, 3'd2, 16'h2222);
        chk("tie_b_next", b_ready, 1'b1);
        chk("wr1_DR", dr_o, 3'd1);
        chk("wr1_Buss", buss, 16'h1111);
        idle();
        chk("wr2_DR", dr_o, 3'd2);
        chk("wr2_Buss", buss, 16'h2222);
        idle();
        chk("idle_regWE", regwe, 1'b0);
        chk("idle_DR_hold", dr_o, 3'd2);

        // Locked burst of 6 from A against a waiting B: AAAA B AA.
        ai = 0;
        for (int c = 0; c < 7; c++) begin
            cyc(1, 1, 1, 3'(ai), 16'hA000 + 16'(ai), 1, 0, 3'd6, 16'hB000 + 16'(c));
            chk("burst_a_ready", a_ready, (c != 4));
            chk("burst_b_ready", b_ready, (c == 4));
            if (a_ready) ai++;
        end
        chk("burst_a_count", ai, 6);
        idle();

        // B alone, locked, 8 cycles: back-to-back grants and writes.
        for (int c = 0; c < 8; c++) begin
            cyc(1, 0, 0, 0, 0, 1, 1, 3'(c), 16'hC000 + 16'(c));
            chk("b_only_ready", b_ready, 1'b1);
            if (c > 0) chk("b_only_regWE", regwe, 1'b1);
        end
        idle();
        chk("b_only_last_regWE", regwe, 1'b1);
        idle();

        // Forwarding of the write in flight.
        cyc(1, 1, 0, 3'd3, 16'hBEEF, 0, 0, 0, 0);
        sr1 = 3'd3; ra_in = 16'h0000;
        idle();
        chk("fwd_ra_out", ra_out, FWD ? 16'hBEEF : 16'h0000);
        sr1 = 3'd0; ra_in = 16'h5A5A;

        // Reset right after an accepted write discards it; A wins after release.
        cyc(1, 1, 0, 3'd6, 16'h6666, 0, 0, 0, 0);
        chk("pre_rst_accept", a_ready, 1'b1);
        cyc(0, 1, 0, 3'd6, 16'h6666, 1, 0, 3'd5, 16'h7777);
        chk("mid_rst_regWE", regwe, 1'b0);
        chk("mid_rst_a_ready", a_ready, 1'b0);
        chk("mid_rst_b_ready", b_ready, 1'b0);
        cyc(1, 1, 0, 3'd6, 16'h6666, 1, 0, 3'd5, 16'h7777);
        chk("after_rst_regWE", regwe, 1'b0);
        chk("after_rst_a_wins", a_ready, 1'b1);
        idle();
        idle();

        // Same destination from both: A (0001) then B (0002), nothing merged.
        cyc(1, 0, 0, 0, 0, 1, 0, 3'd0, 16'h0F0F);
        cyc(1, 1, 0, 3'd7, 16'h0001, 1, 0, 3'd7, 16'h0002);
        chk("same_dr_a", a_ready, 1'b1);
        cyc(1, 0, 0, 0, 0, 1, 0, 3'd7, 16'h0002);
        chk("same_dr_b", b_ready, 1'b1);
        chk("same_dr_w1", buss, 16'h0001);
        idle();
        chk("same_dr_w2_we", regwe, 1'b1);
        chk("same_dr_final", buss, 16'h0002);
        idle();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            rst_n   = ($urandom_range(0, 79) != 0);
            a_valid = ($urandom_range(0, 9) < 7);
            a_lock  = ($urandom_range(0, 9) < 6);
            a_dr    = 3'($urandom);
            a_data  = 16'($urandom);
            b_valid = ($urandom_range(0, 9) < 7);
            b_lock  = ($urandom_range(0, 9) < 5);
            b_dr    = 3'($urandom);
            b_data  = 16'($urandom);
            sr1     = 3'($urandom);
            sr2     = 3'($urandom);
            ra_in   = 16'($urandom);
            rb_in   = 16'($urandom);
        end
        idle();
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regwr_arbiter.md
REGWR_ARBITER -- requirements
Module: regwr_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 4, SHALL set the maximum consecutive locked grants to one requester while the other is waiting.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  SHALL be a synchronous, active-low reset: low at a rising clk edge resets the block.
REQ-004 a_valid, a_lock  in  1 each; a_dr  in  3; a_data  in  16  SHALL form the requester A (ALU writeback) write request.
REQ-005 a_ready  out  1  SHALL indicate that requester A's request is accepted this cycle.
REQ-006 b_valid, b_lock, b_dr, b_data, b_ready SHALL mirror the A ports for requester B (memory load).
REQ-007 regWE  out  1; DR  out  3; Buss  out  16  SHALL drive the register-file write port.
REQ-008 sr1, sr2  in  3; ra_in, rb_in  in  16  SHALL carry the register-file read addresses and read data.
REQ-009 ra_out, rb_out  out  16  SHALL be the read data delivered to the datapath.

Function
REQ-010 At most one of a_ready/b_ready SHALL be high per cycle; both are combinational from valids and internal state; a transfer occurs on valid&ready.
REQ-011 Only one valid requester: it SHALL be granted.
REQ-012 Both valid, burst active, owner valid, burst_cnt < BURST_MAX: the owner SHALL be granted.
REQ-013 Both valid otherwise: the requester not granted last SHALL be granted (round-robin).
REQ-014 Transfer with lock=1 SHALL make that requester burst owner and increment burst_cnt, which saturates at BURST_MAX.
REQ-015 The burst SHALL end (owner and burst_cnt cleared) when the owner transfers with lock=0, the owner deasserts valid, or the other requester is granted.
REQ-016 When burst_cnt = BURST_MAX and the other requester is valid, the other SHALL be granted; with the other idle the owner keeps winning.
REQ-017 A transfer in cycle N SHALL produce regWE=1, DR=dr, Buss=data in cycle N+1 (latency one cycle, one write per cycle, full throughput).
REQ-018 A cycle with no transfer SHALL give regWE=0 in the next cycle; DR and Buss hold their last value.
REQ-019 Requests from both requesters to the same DR SHALL each be written in grant order; no merging or dropping.

Reset
REQ-020 While reset is low, a_ready and b_ready SHALL be 0; a request presented during that cycle is not accepted.
REQ-021 After reset: regWE=0, DR=0, Buss=0, burst cleared, last-grant=B, so A wins the first tie.
REQ-022 Reset during a burst or with a write staged SHALL discard both; the staged write never reaches the register file.

Configuration
REQ-023 With REGWR_FWD_EN defined: ra_out SHALL be Buss when regWE=1 and DR=sr1, else ra_in; rb_out likewise with sr2.
REQ-024 Without REGWR_FWD_EN: ra_out=ra_in and rb_out=rb_in; ports unchanged; no other behaviour differs.

Structure
REQ-025 The shared package/header SHALL hold WORD_W=16, REG_IDX_W=3 and the BURST_MAX default; no local redefinition.
REQ-026 Two-way round-robin grant logic with the burst override SHALL be a sub-module rr_arb2; staging register and forwarding stay in regwr_arbiter.

Verification
REQ-027 After reset, A(dr=1,data=16'h1111) and B(dr=2,data=16'h2222) valid together -> a_ready first; regWE with DR=1/16'h1111, next cycle DR=2/16'h2222.
REQ-028 A locked burst of 6 writes dr=0..5 with B valid, BURST_MAX=4 -> A granted 4 cycles, B granted 5th cycle, A resumes after.
REQ-029 Only B valid with lock=1 for 8 cycles -> 8 consecutive grants, regWE high 8 cycles with no gaps.
REQ-030 A transfer dr=3 data=16'hBEEF, next cycle sr1=3, ra_in=16'h0000 -> ra_out=16'hBEEF with REGWR_FWD_EN, 16'h0000 without.
REQ-031 A accepted in cycle N, reset low in cycle N+1 -> regWE=0 in N+1 and N+2, readies 0 during reset, A wins first tie after release.
REQ-032 A and B both write dr=7 (16'h0001 then 16'h0002) -> two regWE cycles in grant order; final Buss=16'h0002.
